// File: rtl/ext_mem_bridge_if.sv
// Bus-side and memory-side signal bundle for ext_mem_bridge.
// The bridge uses the slave view; whatever drives the bus and models the memory uses master.
interface ext_mem_bridge_if #(
    parameter int DWidth = 32
) ();
    logic              sel_i;
    logic              trans_i;
    logic              write_i;
    logic [DWidth-1:0] addr_i;
    logic [DWidth-1:0] wdata_i;
    logic              ready_i;
    logic              ready_o;
    logic              resp_o;
    logic [DWidth-1:0] rdata_o;
    logic              mem_ready_i;
    logic [DWidth-1:0] mem_rdata_i;
    logic              mem_req_o;
    logic              mem_write_o;
    logic [DWidth-1:0] mem_addr_o;
    logic [DWidth-1:0] mem_wdata_o;

    modport slave (
        input  sel_i, trans_i, write_i, addr_i, wdata_i, ready_i,
        input  mem_ready_i, mem_rdata_i,
        output ready_o, resp_o, rdata_o,
        output mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output sel_i, trans_i, write_i, addr_i, wdata_i, ready_i,
        output mem_ready_i, mem_rdata_i,
        input  ready_o, resp_o, rdata_o,
        input  mem_req_o, mem_write_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/ext_mem_bridge.sv
// Pipelined-bus slave that forwards word-aligned transfers to an external memory,
// answering misaligned or timed-out accesses with a two-cycle error response.
module ext_mem_bridge #(
    parameter int DWidth        = 32,
    parameter int TimeoutCycles = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ext_mem_bridge_if.slave  bus
);
    localparam int CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ERR1 = 2'd2;
    localparam logic [1:0] ERR2 = 2'd3;

    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [DWidth-1:0]   addr_q;
    logic                write_q;
    logic [CntWidth-1:0] cnt;
    logic                accept;
    logic                take;
    logic                aligned;
    logic                at_limit;

    assign accept   = bus.sel_i & bus.trans_i & bus.ready_i;
    assign aligned  = (bus.addr_i[1:0] == 2'b00);
    assign at_limit = (cnt == CntWidth'(TimeoutCycles - 1));

    // A new address phase is only taken where the previous transfer is finished.
    always_comb begin
        take = 1'b0;
        case (state)
            IDLE, ERR2: take = accept;
            REQ:        take = accept & bus.mem_ready_i;
            default:    take = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR2: begin
                if (take) state_next = aligned ? REQ : ERR1;
                else      state_next = IDLE;
            end
            REQ: begin
                if (bus.mem_ready_i) begin
                    if (take) state_next = aligned ? REQ : ERR1;
                    else      state_next = IDLE;
                end else if (at_limit) begin
                    state_next = ERR1;
                end else begin
                    state_next = REQ;
                end
            end
            ERR1:    state_next = ERR2;
            default: state_next = IDLE;
        endcase
    end

    // The counter saturates at the limit so it can never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                addr_q  <= bus.addr_i;
                write_q <= bus.write_i;
                cnt     <= '0;
            end else if (state == REQ && !bus.mem_ready_i && !at_limit) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        bus.ready_o   = 1'b1;
        bus.resp_o    = 1'b0;
        bus.rdata_o   = '0;
        bus.mem_req_o = 1'b0;
        case (state)
            REQ: begin
                bus.mem_req_o = 1'b1;
                bus.ready_o   = bus.mem_ready_i;
                if (bus.mem_ready_i && !write_q) bus.rdata_o = bus.mem_rdata_i;
            end
            ERR1: begin
                bus.ready_o = 1'b0;
                bus.resp_o  = 1'b1;
            end
            ERR2: begin
                bus.ready_o = 1'b1;
                bus.resp_o  = 1'b1;
            end
            default: begin
                bus.ready_o = 1'b1;
                bus.resp_o  = 1'b0;
            end
        endcase
    end

    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_write_o = write_q;
    assign bus.mem_wdata_o = bus.wdata_i;
endmodule

// File: tb/tb_ext_mem_bridge.sv
// Directed bench for ext_mem_bridge: inputs change 1 time unit after each rising
// edge, outputs are compared on the falling edge against hand-computed values.
module tb_ext_mem_bridge;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ext_mem_bridge_if #(.DWidth(32)) bus ();

    ext_mem_bridge #(.DWidth(32), .TimeoutCycles(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag, input logic rdy, input logic rsp, input logic req);
        check1({tag, "_ready"}, bus.ready_o, rdy);
        check1({tag, "_resp"}, bus.resp_o, rsp);
        check1({tag, "_memreq"}, bus.mem_req_o, req);
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a);
        bus.sel_i   = 1'b1;
        bus.trans_i = 1'b1;
        bus.write_i = wr;
        bus.addr_i  = a;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sel_i = 1'b0;
        bus.trans_i = 1'b0;
        bus.write_i = 1'b0;
        bus.addr_i = '0;
        bus.wdata_i = '0;
        bus.ready_i = 1'b1;
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = '0;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check_bus("reset", 1'b1, 1'b0, 1'b0);
        check("reset_rdata", bus.rdata_o, 32'h0);
        check1("reset_memwrite", bus.mem_write_o, 1'b0);
        check("reset_memaddr", bus.mem_addr_o, 32'h0);

        // Ignored address phases and a stray mem_ready_i pulse in IDLE
        step();
        bus.sel_i = 1'b0; bus.trans_i = 1'b1; bus.addr_i = 32'h10;
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_0001;
        @(negedge clk);
        check("stray_rdata", bus.rdata_o, 32'h0);
        step();
        bus.sel_i = 1'b1; bus.ready_i = 1'b0;
        @(negedge clk);
        check_bus("nosel", 1'b1, 1'b0, 1'b0);
        step();
        bus.ready_i = 1'b1; bus.trans_i = 1'b0;
        @(negedge clk);
        check_bus("noready", 1'b1, 1'b0, 1'b0);

        // Single-cycle read of 0x10
        addr_phase(1'b0, 32'h10);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        step();
        bus.trans_i = 1'b0;
        @(negedge clk);
        check_bus("rd1", 1'b1, 1'b0, 1'b1);
        check("rd1_rdata", bus.rdata_o, 32'hDEAD_BEEF);
        check("rd1_memaddr", bus.mem_addr_o, 32'h10);
        check1("rd1_memwrite", bus.mem_write_o, 1'b0);
        step();
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        check_bus("rd1_idle", 1'b1, 1'b0, 1'b0);
        check("rd1_idle_rdata", bus.rdata_o, 32'h0);

        // Write to 0x20, memory ready on the fourth REQ cycle
        addr_phase(1'b1, 32'h20);
        step();
        bus.trans_i = 1'b0; bus.wdata_i = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_bus($sformatf("wr_wait%0d", i), 1'b0, 1'b0, 1'b1);
            check1("wr_memwrite", bus.mem_write_o, 1'b1);
            check("wr_wdata", bus.mem_wdata_o, 32'h1234_5678);
            check("wr_memaddr", bus.mem_addr_o, 32'h20);
            step();
        end
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        check_bus("wr_done", 1'b1, 1'b0, 1'b1);
        check("wr_done_rdata", bus.rdata_o, 32'h0);
        check("wr_done_wdata", bus.mem_wdata_o, 32'h1234_5678);
        step();
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        check_bus("wr_idle", 1'b1, 1'b0, 1'b0);

        // Misaligned access 0x13
        addr_phase(1'b0, 32'h13);
        step();
        bus.trans_i = 1'b0;
        @(negedge clk);
        check_bus("mis_err1", 1'b0, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_bus("mis_err2", 1'b1, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_bus("mis_idle", 1'b1, 1'b0, 1'b0);

        // Timeout: memory never answers
        addr_phase(1'b0, 32'h40);
        step();
        bus.trans_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_bus($sformatf("to_req%0d", i), 1'b0, 1'b0, 1'b1);
            step();
        end
        @(negedge clk);
        check_bus("to_err1", 1'b0, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_bus("to_err2", 1'b1, 1'b1, 1'b0);
        step();
        @(negedge clk);
        check_bus("to_idle", 1'b1, 1'b0, 1'b0);

        // mem_ready_i on the last allowed cycle completes normally
        addr_phase(1'b0, 32'h44);
        step();
        bus.trans_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check1("lim_wait_memreq", bus.mem_req_o, 1'b1);
            step();
        end
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'h0BAD_F00D;
        @(negedge clk);
        check_bus("lim_done", 1'b1, 1'b0, 1'b1);
        check("lim_rdata", bus.rdata_o, 32'h0BAD_F00D);
        step();
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        check_bus("lim_idle", 1'b1, 1'b0, 1'b0);

        // Back-to-back reads 0x0 then 0x4
        addr_phase(1'b0, 32'h0);
        bus.mem_ready_i = 1'b1; bus.mem_rdata_i = 32'hAAAA_0000;
        step();
        addr_phase(1'b0, 32'h4);
        @(negedge clk);
        check_bus("b2b_first", 1'b1, 1'b0, 1'b1);
        check("b2b_first_addr", bus.mem_addr_o, 32'h0);
        check("b2b_first_rdata", bus.rdata_o, 32'hAAAA_0000);
        step();
        bus.trans_i = 1'b0; bus.mem_rdata_i = 32'hBBBB_0004;
        @(negedge clk);
        check_bus("b2b_second", 1'b1, 1'b0, 1'b1);
        check("b2b_second_addr", bus.mem_addr_o, 32'h4);
        check("b2b_second_rdata", bus.rdata_o, 32'hBBBB_0004);
        step();
        bus.mem_ready_i = 1'b0;
        @(negedge clk);
        check_bus("b2b_idle", 1'b1, 1'b0, 1'b0);

        // Reset during the third wait cycle of a read
        addr_phase(1'b0, 32'h80);
        step();
        bus.trans_i = 1'b0;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        check1("rst_wait3_memreq", bus.mem_req_o, 1'b1);
        step();
        rst = 1'b0;
        @(negedge clk);
        check_bus("rst_idle", 1'b1, 1'b0, 1'b0);
        check("rst_memaddr", bus.mem_addr_o, 32'h0);
        step();
        @(negedge clk);
        check_bus("rst_discard", 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ext_mem_bridge.md
EXT_MEM_BRIDGE -- requirements
Module: ext_mem_bridge

Interface
REQ-001 The module SHALL have parameter DWidth, default 32, giving the bus and memory data/address width.
REQ-002 The module SHALL have parameter TimeoutCycles, default 16, giving the maximum cycles mem_req_o stays high without mem_ready_i.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock.
REQ-004 The module SHALL have port rst_i, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-005 The module SHALL have port sel_i, input, 1, bus slave select for this bridge.
REQ-006 The module SHALL have port trans_i, input, 1, master transfer request in the address phase.
REQ-007 The module SHALL have port write_i, input, 1, address-phase direction, 1 = write.
REQ-008 The module SHALL have port addr_i, input, DWidth, address-phase byte address.
REQ-009 The module SHALL have port wdata_i, input, DWidth, write data, valid in the data phase.
REQ-010 The module SHALL have port ready_i, input, 1, global bus ready; the previous data phase ends when it is high.
REQ-011 The module SHALL have port ready_o, output, 1, slave ready-out to the bus.
REQ-012 The module SHALL have port resp_o, output, 1, slave response, 1 = error.
REQ-013 The module SHALL have port rdata_o, output, DWidth, read data to the bus.
REQ-014 The module SHALL have ports mem_ready_i (in, 1) and mem_rdata_i (in, DWidth), the external memory's completion and read data.
REQ-015 The module SHALL have ports mem_req_o (out, 1), mem_write_o (out, 1), mem_addr_o (out, DWidth) and mem_wdata_o (out, DWidth), the external memory request.

Function
REQ-016 An address phase SHALL be accepted on a rising edge where sel_i & trans_i & ready_i = 1; addr_i and write_i SHALL be captured into registers.
REQ-017 Address phases with sel_i = 0, trans_i = 0 or ready_i = 0 SHALL be ignored.
REQ-018 The FSM SHALL have the states IDLE, REQ, ERR1 and ERR2.
REQ-019 From IDLE, an accepted aligned address (addr_i[1:0] = 0) SHALL move the FSM to REQ, and an accepted misaligned address SHALL move it to ERR1.
REQ-020 In REQ the outputs SHALL be: mem_req_o = 1; mem_addr_o and mem_write_o from the captured registers; mem_wdata_o = wdata_i (combinational).
REQ-021 In REQ with mem_ready_i = 0, the outputs SHALL be ready_o = 0 and resp_o = 0.
REQ-022 In REQ with mem_ready_i = 1, the outputs SHALL be ready_o = 1 and resp_o = 0 in the same cycle; for reads, rdata_o = mem_rdata_i.
REQ-023 In every other state or condition, rdata_o SHALL be 0.
REQ-024 On REQ completion, a new accepted address in that same cycle SHALL go to REQ or ERR1 (back-to-back, no idle cycle); otherwise the FSM SHALL go to IDLE.
REQ-025 A transfer SHALL complete with a minimum latency of 1 data-phase cycle when mem_ready_i is already high.
REQ-026 The timeout counter SHALL be cleared on REQ entry and SHALL increment in each REQ cycle with mem_ready_i = 0.
REQ-027 When the timeout counter reaches TimeoutCycles-1 with mem_ready_i = 0, the FSM SHALL go to ERR1, so mem_req_o is high for exactly TimeoutCycles cycles.
REQ-028 The timeout counter width SHALL be clog2(TimeoutCycles), and the counter SHALL never wrap.
REQ-029 ERR1 SHALL output ready_o = 0, resp_o = 1 and mem_req_o = 0, and then move to ERR2.
REQ-030 ERR2 SHALL output ready_o = 1, resp_o = 1 and mem_req_o = 0.
REQ-031 ERR2 SHALL take an accepted address as in IDLE, and otherwise move to IDLE.
REQ-032 IDLE SHALL output ready_o = 1, resp_o = 0 and mem_req_o = 0.
REQ-033 mem_req_o SHALL never be asserted for a misaligned address.
REQ-034 A mem_ready_i pulse outside REQ SHALL be ignored.
REQ-035 mem_ready_i arriving in the same cycle that the timeout limit is reached SHALL complete the transfer normally, with no error.

Reset
REQ-036 While rst_i = 1 at a clock edge, the state, captured registers and counter SHALL clear: IDLE, address 0, write 0, count 0.
REQ-037 After reset the outputs SHALL be: ready_o = 1, resp_o = 0, rdata_o = 0, mem_req_o = 0, mem_write_o = 0 and mem_addr_o = 0.
REQ-038 A reset asserted mid-REQ SHALL drop mem_req_o on the next edge with no error response, and the aborted transfer SHALL be discarded.

Verification
REQ-039 Bench scenario: read 0x0000_0010 with mem_ready_i high on the first REQ cycle and mem_rdata_i = 0xDEAD_BEEF -> mem_req_o high for 1 cycle; ready_o = 1, rdata_o = 0xDEAD_BEEF and resp_o = 0 in that cycle.
REQ-040 Bench scenario: write 0x0000_0020 with wdata 0x1234_5678 and memory ready after 3 cycles -> ready_o = 0 for 3 cycles, then 1; mem_write_o = 1 and mem_wdata_o = 0x1234_5678 throughout.
REQ-041 Bench scenario: access 0x0000_0013 -> mem_req_o stays 0; ready_o/resp_o = 0/1 then 1/1; then IDLE.
REQ-042 Bench scenario: mem_ready_i held 0 with TimeoutCycles = 16 -> mem_req_o high exactly 16 cycles, then the two-cycle error response.
REQ-043 Bench scenario: back-to-back reads 0x0 and 0x4, the second address phase in the first's completion cycle -> two consecutive REQ sequences with no IDLE cycle between them.
REQ-044 Bench scenario: rst_i = 1 for 1 cycle during the third REQ wait cycle -> next cycle IDLE, mem_req_o = 0, ready_o = 1, resp_o = 0.
